// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath: the 3-bit ALUControl codes
// produced by the control decoder and the multi-cycle sequencer state
// encoding (also consumed by the decoder to know when the ALU is busy).
// ---------------------------------------------------------------------------
package alu_pkg;

    // ALUControl codes from the control decoder
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_LSR  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_MOV  = 3'b011;
    localparam logic [2:0] ALU_MOD  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b110;
    localparam logic [2:0] ALU_NONE = 3'b111;

    // Multi-cycle sequencer states
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_MUL  = 2'd1,
        SEQ_MOD  = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_e;

    // True for the codes the sequencer takes over from the single-cycle ALU
    function automatic logic is_multicycle(input logic [2:0] ctrl);
        return (ctrl == ALU_MUL) || (ctrl == ALU_MOD);
    endfunction

endpackage

// File: rtl/alu_iter_step.sv
// ---------------------------------------------------------------------------
// alu_iter_step
// Purely combinational single iteration of the multi-cycle ALU.
//   Multiply (is_mod=0): shift-add. acc += opa when opb[0]; opa <<= 1; opb >>= 1.
//   Remainder (is_mod=1): restoring division step. The next dividend bit (opa MSB)
//                   is shifted into the remainder, divisor subtracted when it
//                   fits; opa <<= 1 exposes the next dividend bit.
// Ports:
//   is_mod              in   selects MOD step, otherwise MUL step
//   acc                 in   accumulator (MUL) / partial remainder (MOD)
//   opa                 in   multiplicand (MUL) / remaining dividend (MOD)
//   opb                 in   multiplier (MUL) / divisor (MOD)
//   acc_next/opa_next/opb_next   out  register values after this step
// ---------------------------------------------------------------------------
module alu_iter_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_mod,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] opa_next,
    output logic [WIDTH-1:0] opb_next
);

    logic [WIDTH:0] rem_shift;
    logic           rem_ge;

    // The stored remainder is always below the divisor, so it fits in WIDTH
    // bits; only the shifted value needs the extra bit for the compare. When
    // the subtraction happens the true difference is below the divisor, so
    // a WIDTH-bit subtract of the low bits gives the exact remainder.
    always_comb begin
        rem_shift = {acc, opa[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, opb});
        acc_next  = acc;
        opa_next  = opa << 1;
        opb_next  = opb;
        if (is_mod) begin
            if (rem_ge) begin
                acc_next = rem_shift[WIDTH-1:0] - opb;
            end else begin
                acc_next = rem_shift[WIDTH-1:0];
            end
        end else begin
            if (opb[0]) begin
                acc_next = acc + opa;
            end
            opb_next = opb >> 1;
        end
    end

endmodule

// File: rtl/alu_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// alu_multicycle_sequencer
// Runs the multi-cycle ALU operations (MUL = 3'b110, MOD = 3'b100) beside the
// single-cycle ALU. An accepted op is iterated one bit per cycle, the
// pipeline is stalled while busy, and done pulses for one cycle with the
// result. Every other ALUControl code is left to the single-cycle ALU.
// Ports:
//   clk          in   clock, all state on posedge
//   rst          in   asynchronous active-high reset
//   start        in   decode-stage op valid
//   alu_ctrl     in   ALUControl code
//   a, b         in   unsigned operands (multiplicand/dividend, multiplier/divisor)
//   stall        out  freeze upstream stages (combinational)
//   done         out  one-cycle pulse, result and div_by_zero valid
//   result       out  low WIDTH bits of a*b, or a mod b (held until next accept)
//   div_by_zero  out  MOD issued with b==0 (held until next accept)
// ---------------------------------------------------------------------------
module alu_multicycle_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = SEQ_IDLE;
    localparam logic [1:0] ST_MUL  = SEQ_MUL;
    localparam logic [1:0] ST_MOD  = SEQ_MOD;
    localparam logic [1:0] ST_DONE = SEQ_DONE;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] opa_next;
    logic [WIDTH-1:0] opb_next;
    logic             accept;
    logic             last_step;

    alu_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_mod   (state == ST_MOD),
        .acc      (acc),
        .opa      (opa),
        .opb      (opb),
        .acc_next (acc_next),
        .opa_next (opa_next),
        .opb_next (opb_next)
    );

    assign accept    = (state == ST_IDLE) && start && is_multicycle(alu_ctrl);
    assign last_step = (cnt == CNT_W'(1));

    // Stall covers the accept cycle too, so the instruction is held from the
    // moment it is seen. It drops in DONE so the held instruction retires
    // together with the result. Gated by rst so a reset never stalls.
    assign stall = !rst && (accept || (state == ST_MUL) || (state == ST_MOD));

    // Sequencer FSM plus datapath registers. done is set on the edge that
    // enters DONE and cleared by default on every other edge, giving a
    // single-cycle pulse. A zero divisor is caught in the first remainder
    // cycle, before any step has shifted the dividend, so opa still
    // holds the original a.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc         <= '0;
            opa         <= '0;
            opb         <= '0;
            result      <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        opa         <= a;
                        opb         <= b;
                        acc         <= '0;
                        cnt         <= CNT_W'(WIDTH);
                        div_by_zero <= 1'b0;
                        state       <= (alu_ctrl == ALU_MUL) ? ST_MUL : ST_MOD;
                    end
                end
                ST_MUL: begin
                    acc <= acc_next;
                    opa <= opa_next;
                    opb <= opb_next;
                    cnt <= cnt - CNT_W'(1);
                    if (last_step) begin
                        result <= acc_next;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_MOD: begin
                    if (opb == '0) begin
                        result      <= opa;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_DONE;
                    end else begin
                        acc <= acc_next;
                        opa <= opa_next;
                        opb <= opb_next;
                        cnt <= cnt - CNT_W'(1);
                        if (last_step) begin
                            result <= acc_next;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
